pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_pkg.sv | 73 +++++++
 rtl/pipe_stall_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_stall_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the FSM state enum, XZR index and the register/counter widths.
package pipe_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int CNT_W  = 32;
  localparam int WCNT_W = 8;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pr1_en;
    logic pr2_en;
    logic pr3_en;
    logic pr4_en;
    logic pr2_bubble;
    logic pr4_bubble;
  } ctrl_t;

  // Every stage advances, nothing squashed.
  function automatic ctrl_t ctrl_go();
    ctrl_t c;
    c.pc_en      = 1'b1;
    c.pr1_en     = 1'b1;
    c.pr2_en     = 1'b1;
    c.pr3_en     = 1'b1;
    c.pr4_en     = 1'b1;
    c.pr2_bubble = 1'b0;
    c.pr4_bubble = 1'b0;
    return c;
  endfunction

  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX.
  function automatic ctrl_t ctrl_stall();
    ctrl_t c;
    c.pc_en      = 1'b0;
    c.pr1_en     = 1'b0;
    c.pr2_en     = 1'b1;
    c.pr3_en     = 1'b1;
    c.pr4_en     = 1'b1;
    c.pr2_bubble = 1'b1;
    c.pr4_bubble = 1'b0;
    return c;
  endfunction

  // Memory wait: freeze the front, drain a bubble into MEM/WB.
  function automatic ctrl_t ctrl_hold();
    ctrl_t c;
    c.pc_en      = 1'b0;
    c.pr1_en     = 1'b0;
    c.pr2_en     = 1'b0;
    c.pr3_en     = 1'b0;
    c.pr4_en     = 1'b1;
    c.pr2_bubble = 1'b0;
    c.pr4_bubble = 1'b1;
    return c;
  endfunction

  // Everything frozen, no bubbles.
  function automatic ctrl_t ctrl_dead();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard detector between the EX and ID stages.
// Ports: id_rn/id_rm (ID sources), ex_memread/ex_rd (EX load), load_use.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rd_live;
  logic rd_match;

  // XZR reads as zero, so a load targeting it never feeds anyone.
  assign rd_live  = ex_memread && (ex_rd != XZR);
  assign rd_match = (ex_rd == id_rn) || (ex_rd == id_rm);
  assign load_use = rd_live && rd_match;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: memory-wait freeze, load-use stall, timeout.
// Ports: clock/reset, ID/EX/MEM hazard inputs, dmem_req/dmem_ack,
// stage enables + bubbles, sticky err, stall_cycles.
// Option: PIPE_STALL_CNT_EN enables the stall_cycles counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             pr1_en,
  output logic             pr2_en,
  output logic             pr3_en,
  output logic             pr4_en,
  output logic             pr2_bubble,
  output logic             pr4_bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(WAIT_TIMEOUT);
  localparam logic [WCNT_W-1:0] WMAX = '1;

  state_t            st;
  state_t            st_eff;
  logic [WCNT_W-1:0] wait_cnt;
  logic              memacc;
  logic              load_use;
  ctrl_t             ctrl;

  assign memacc = mem_memread || mem_memwrite;

  hazard_detect u_hazard (
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  // While reset is held the outputs decode as if already in RUN.
  assign st_eff = reset ? RUN : st;

  always_comb begin
    ctrl     = ctrl_dead();
    dmem_req = 1'b0;
    err      = 1'b0;
    unique case (st_eff)
      RUN: begin
        dmem_req = memacc;
        if (memacc && !dmem_ack) begin
          ctrl = ctrl_hold();
        end else if (load_use) begin
          ctrl = ctrl_stall();
        end else begin
          ctrl = ctrl_go();
        end
      end
      MEM_WAIT: begin
        dmem_req = memacc;
        if (!dmem_ack) begin
          ctrl = ctrl_hold();
        end else if (load_use) begin
          ctrl = ctrl_stall();
        end else begin
          ctrl = ctrl_go();
        end
      end
      ERROR: begin
        err = 1'b1;
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  assign pc_en      = ctrl.pc_en;
  assign pr1_en     = ctrl.pr1_en;
  assign pr2_en     = ctrl.pr2_en;
  assign pr3_en     = ctrl.pr3_en;
  assign pr4_en     = ctrl.pr4_en;
  assign pr2_bubble = ctrl.pr2_bubble;
  assign pr4_bubble = ctrl.pr4_bubble;

  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= RUN;
      wait_cnt <= '0;
    end else begin
      unique case (st)
        RUN: begin
          if (memacc && !dmem_ack) begin
            st       <= MEM_WAIT;
            wait_cnt <= WCNT_W'(1);
          end
        end
        MEM_WAIT: begin
          // An ack in the timeout cycle still completes the access.
          if (dmem_ack) begin
            st       <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt == TMO) begin
              st <= ERROR;
            end
            if (wait_cnt != WMAX) begin
              wait_cnt <= wait_cnt + WCNT_W'(1);
            end
          end
        end
        ERROR: begin
          st <= ERROR;
        end
        default: begin
          st <= ERROR;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Counts every frozen-PC cycle, ERROR included; saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!ctrl.pc_en && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl with WAIT_TIMEOUT=4.
// Behavioural model plus directed vectors with literal expectations.
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rn;
  logic [4:0]  id_rm;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_memread;
  logic        mem_memwrite;
  logic        dmem_ack;
  logic        dmem_req;
  logic        pc_en;
  logic        pr1_en;
  logic        pr2_en;
  logic        pr3_en;
  logic        pr4_en;
  logic        pr2_bubble;
  logic        pr4_bubble;
  logic        err;
  logic [31:0] stall_cycles;

  pipe_stall_ctrl #(.WAIT_TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .pc_en        (pc_en),
    .pr1_en       (pr1_en),
    .pr2_en       (pr2_en),
    .pr3_en       (pr3_en),
    .pr4_en       (pr4_en),
    .pr2_bubble   (pr2_bubble),
    .pr4_bubble   (pr4_bubble),
    .err          (err),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: pend = consecutive unacknowledged memory cycles so far,
  // dead = timed out, stalls = frozen-PC cycles since reset.
  int         pend = 0;
  bit         dead = 1'b0;
  int         stalls = 0;
  logic [8:0] exp_v;
  bit         exp_hold;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Vector order: req pc pr1 pr2 pr3 pr4 b2 b4 err
  task automatic model_eval();
    bit lu;
    bit ma;
    bit waiting;
    lu = ex_memread && (ex_rd != 5'd31) &&
         ((ex_rd == id_rn) || (ex_rd == id_rm));
    ma = mem_memread || mem_memwrite;
    waiting  = !reset && (pend > 0);
    exp_hold = !dmem_ack && (ma || waiting);
    if (!reset && dead)
      exp_v = 9'b0_00000_00_1;
    else if (exp_hold)
      exp_v = {ma, 5'b00001, 2'b01, 1'b0};
    else if (lu)
      exp_v = {ma, 5'b00111, 2'b10, 1'b0};
    else
      exp_v = {ma, 5'b11111, 2'b00, 1'b0};
  endtask

  task automatic drive(input logic rst, input logic mr,
                       input logic mw, input logic ack,
                       input logic exmr, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm);
    logic [8:0] act_v;
    int         exp_s;
    reset        = rst;
    mem_memread  = mr;
    mem_memwrite = mw;
    dmem_ack     = ack;
    ex_memread   = exmr;
    ex_rd        = rd;
    id_rn        = rn;
    id_rm        = rm;
    #2;
    model_eval();
    act_v = {dmem_req, pc_en, pr1_en, pr2_en, pr3_en, pr4_en,
             pr2_bubble, pr4_bubble, err};
    chk("outputs", 32'(act_v), 32'(exp_v));
`ifdef PIPE_STALL_CNT_EN
    exp_s = stalls;
`else
    exp_s = 0;
`endif
    chk("stall_cycles", stall_cycles, 32'(exp_s));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      pend   = 0;
      dead   = 1'b0;
      stalls = 0;
    end else begin
      if (!exp_v[7]) stalls++;
      if (!dead) begin
        if (exp_hold) begin
          pend++;
          if (pend > TO) dead = 1'b1;
        end else begin
          pend = 0;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic cyc(input logic rst, input logic mr,
                     input logic mw, input logic ack,
                     input logic exmr, input logic [4:0] rd,
                     input logic [4:0] rn, input logic [4:0] rm);
    drive(rst, mr, mw, ack, exmr, rd, rn, rm);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    mem_memread = 0; mem_memwrite = 0; dmem_ack = 0;
    ex_memread = 0; ex_rd = 0; id_rn = 0; id_rm = 0;
    @(posedge clock);
    @(negedge clock);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state and idle flow
    drive(0, 0, 0, 0, 0, 1, 2, 3);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("idle_pc_en", 32'(pc_en), 32'd1);
    tick();

    // Load-use on rn: one stall, then flow
    drive(0, 0, 0, 0, 1, 5, 5, 9);
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_pr1_en", 32'(pr1_en), 32'd0);
    chk("lu_b2", 32'(pr2_bubble), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 5, 5, 9);
    chk("lu_after_pc", 32'(pc_en), 32'd1);
    tick();

    // Load-use on rm, XZR, non-load match
    cyc(0, 0, 0, 0, 1, 7, 3, 7);
    drive(0, 0, 0, 0, 1, 31, 31, 31);
    chk("xzr_pc_en", 32'(pc_en), 32'd1);
    tick();
    cyc(0, 0, 0, 0, 0, 6, 6, 6);

    // Memory read acked after three unacked cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 1, 2, 3);
      chk("mw_b4", 32'(pr4_bubble), 32'd1);
      chk("mw_pr3", 32'(pr3_en), 32'd0);
      tick();
    end
    drive(0, 1, 0, 1, 0, 1, 2, 3);
    chk("ack_pc_en", 32'(pc_en), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 2, 3);
    chk("ack_state", 32'(dut.st), 32'(RUN));
    tick();

    // Memory priority over load-use, then ack with load-use
    drive(0, 0, 1, 0, 1, 4, 4, 0);
    chk("prio_b2", 32'(pr2_bubble), 32'd0);
    tick();
    cyc(0, 0, 1, 0, 1, 4, 4, 0);
    drive(0, 0, 1, 1, 1, 4, 4, 0);
    chk("ackl_pc_en", 32'(pc_en), 32'd0);
    chk("ackl_b2", 32'(pr2_bubble), 32'd1);
    chk("ackl_b4", 32'(pr4_bubble), 32'd0);
    tick();
    cyc(0, 1, 0, 1, 1, 8, 0, 8);

    // Reset in the middle of a memory wait
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mrst_state", 32'(dut.st), 32'(RUN));
    chk("mrst_wcnt", 32'(dut.wait_cnt), 32'd0);
    chk("mrst_stall", stall_cycles, 32'd0);
    tick();

    // Ack in the final allowed wait cycle avoids the timeout
    for (int i = 0; i < TO; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("edge_err", 32'(err), 32'd0);
    tick();

    // Timeout into ERROR, sticky until reset
    for (int i = 0; i <= TO; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_req", 32'(dmem_req), 32'd0);
    chk("to_pr4", 32'(pr4_en), 32'd0);
    tick();
    drive(0, 1, 0, 1, 1, 3, 3, 3);
    chk("to_sticky", 32'(err), 32'd1);
    tick();
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_rst_err", 32'(err), 32'd0);
    chk("to_rst_st", 32'(dut.st), 32'(RUN));
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic ma;
      r  = ($urandom_range(0, 39) == 0);
      ma = ($urandom_range(0, 2) == 0);
      cyc(r, ma, ($urandom_range(0, 3) == 0),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          5'($urandom_range(29, 31)), 5'($urandom_range(29, 31)),
          5'($urandom_range(29, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
